alu_ctrl: RTL and testbench

Command sequencer directly upstream of the 4-bit ALU (add/sub/mul/and, Init/Done multiplier).
- Accepts one operation per Start/Valid/Ack transaction and latches the operands.
- Drives A/B/Select to the ALU and holds them stable for the whole operation.
- Pulses Init for multiply, then waits for Done with a timeout watchdog.
- Registers the ALU result for a downstream consumer.

---
 rtl/alu_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Command sequencer in front of the 4-bit ALU: accepts one op, drives the ALU,
// handles the Init/Done multiply handshake with a watchdog, and holds the result.
module alu_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned COMB_WAIT = 1,
    parameter int unsigned TIMEOUT   = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     OpA,
    input  logic [WIDTH-1:0]     OpB,
    input  logic [1:0]           OpSel,
    input  logic                 Ack,
    output logic                 Busy,
    output logic                 Valid,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 Carry,
    output logic                 Error,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [1:0]           Select,
    output logic                 Init,
    input  logic                 Done,
    input  logic [2*WIDTH-1:0]   Sal,
    input  logic                 Cout
);

    localparam int unsigned CNT_MAX = (TIMEOUT > COMB_WAIT) ? TIMEOUT : COMB_WAIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [1:0]  SEL_MUL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_PULSE,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Single registered FSM; every output is a flop so the ALU sees glitch-free controls.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            Busy   <= 1'b0;
            Valid  <= 1'b0;
            Result <= '0;
            Carry  <= 1'b0;
            Error  <= 1'b0;
            A      <= '0;
            B      <= '0;
            Select <= 2'b00;
            Init   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        A      <= OpA;
                        B      <= OpB;
                        Select <= OpSel;
                        Error  <= 1'b0;
                        Busy   <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                    if (Select == SEL_MUL) begin
                        Init  <= 1'b1;
                        state <= S_PULSE;
                    end else begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_W'(COMB_WAIT - 1)) begin
                        Result <= Sal;
                        // Only add/sub (Select[1]==0) produce a meaningful carry.
                        Carry  <= ~Select[1] & Cout;
                        Valid  <= 1'b1;
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    Init  <= 1'b0;
                    cnt   <= '0;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // cnt==0 is the first wait cycle: a Done seen there is left over from the previous op.
                    if (Done && (cnt != '0)) begin
                        Result <= Sal;
                        Carry  <= 1'b0;
                        Valid  <= 1'b1;
                        state  <= S_HOLD;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        Result <= '0;
                        Carry  <= 1'b0;
                        Error  <= 1'b1;
                        Valid  <= 1'b1;
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (Ack) begin
                        Valid <= 1'b0;
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: directed ops with a behavioural ALU and a
// schedulable Done line; a negedge monitor pops expectations on accept/Valid.
module tb_alu_ctrl;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic [7:0] res;
        logic       carry;
        logic       err;
        int         lat;
        int         inits;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic [3:0] OpA = 4'h0;
    logic [3:0] OpB = 4'h0;
    logic [1:0] OpSel = 2'b00;
    logic       Done = 1'b0;
    logic [7:0] Sal;
    logic       Cout;
    logic       Busy, Valid, Carry, Error, Init;
    logic [7:0] Result;
    logic [3:0] A, B;
    logic [1:0] Select;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Done schedule, in cycles after the Init (PULSE) cycle
    int drop_k = 0;
    int rise_k = 8;
    int k = -1;

    alu_ctrl #(.WIDTH(4), .COMB_WAIT(1), .TIMEOUT(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .OpA(OpA), .OpB(OpB), .OpSel(OpSel),
        .Ack(Ack), .Busy(Busy), .Valid(Valid), .Result(Result), .Carry(Carry),
        .Error(Error), .A(A), .B(B), .Select(Select), .Init(Init), .Done(Done),
        .Sal(Sal), .Cout(Cout)
    );

    always #5 Clk = ~Clk;

    // Behavioural ALU datapath; Cout is deliberately 1 for mul/and
    logic [4:0] sum5, dif5;
    always_comb begin
        sum5 = {1'b0, A} + {1'b0, B};
        dif5 = {1'b0, A} - {1'b0, B};
        Sal  = 8'h00;
        Cout = 1'b1;
        case (Select)
            2'b00: begin Sal = {3'b000, sum5}; Cout = sum5[4]; end
            2'b01: begin Sal = {4'h0, dif5[3:0]}; Cout = dif5[4]; end
            2'b10: Sal = {4'h0, A} * {4'h0, B};
            default: Sal = {4'h0, A & B};
        endcase
    end

    always @(negedge Clk) begin
        if (!Rst) begin
            k    = -1;
            Done = 1'b0;
        end else begin
            if (Init) k = 0;
            else if (k >= 0 && k < 100000) k++;
            if (k >= 0) begin
                if (k >= rise_k) Done = 1'b1;
                else if (k >= drop_k) Done = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop on accept (Busy rise), compare on Valid rise
    exp_t cur;
    bit   active = 0, moved = 0, prev_busy = 0, prev_valid = 0;
    int   cyc = 0, start_cyc = 0, init_cnt = 0;

    always @(negedge Clk) begin
        if (!Rst) begin
            active     = 0;
            prev_busy  = 0;
            prev_valid = 0;
        end else begin
            cyc++;
            if (Busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 32'(Busy), 32'(0));
                end else begin
                    cur       = exp_q.pop_front();
                    active    = 1;
                    moved     = 0;
                    start_cyc = cyc;
                    init_cnt  = 0;
                    chk("latched_ops", {22'h0, A, B, Select}, {22'h0, cur.a, cur.b, cur.sel});
                end
            end
            if (active && Init) init_cnt++;
            if (active && Busy && ({A, B, Select} !== {cur.a, cur.b, cur.sel})) moved = 1;
            if (active && Valid && !prev_valid) begin
                chk("result", 32'(Result), 32'(cur.res));
                chk("carry", 32'(Carry), 32'(cur.carry));
                chk("error", 32'(Error), 32'(cur.err));
                chk("latency", 32'(cyc - start_cyc), 32'(cur.lat));
                chk("init_pulses", 32'(init_cnt), 32'(cur.inits));
            end
            if (active && prev_busy && !Busy) begin
                chk("ops_stable", 32'(moved), 32'(0));
                active = 0;
            end
            prev_busy  = Busy;
            prev_valid = Valid;
        end
    end

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                        input logic [7:0] res, input logic carry, input logic err,
                        input int lat, input int inits);
        exp_t e;
        e.a = a; e.b = b; e.sel = sel; e.res = res;
        e.carry = carry; e.err = err; e.lat = lat; e.inits = inits;
        exp_q.push_back(e);
    endtask

    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
        @(negedge Clk);
        OpA = a; OpB = b; OpSel = sel; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!Valid && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk(name, 32'(Valid), 32'(1));
    endtask

    task automatic ack_op();
        Ack = 1'b1;
        chk("busy_before_ack", 32'(Busy), 32'(1));
        @(negedge Clk);
        Ack = 1'b0;
        chk("busy_after_ack", 32'(Busy), 32'(0));
        chk("valid_after_ack", 32'(Valid), 32'(0));
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                          input logic [7:0] res, input logic carry, input logic err,
                          input int lat, input int inits, input string name);
        push(a, b, sel, res, carry, err, lat, inits);
        start_op(a, b, sel);
        wait_valid(name);
        ack_op();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        chk("rst_busy", 32'(Busy), 32'(0));
        chk("rst_valid", 32'(Valid), 32'(0));
        chk("rst_result", 32'(Result), 32'(0));
        chk("rst_init", 32'(Init), 32'(0));
        chk("rst_error", 32'(Error), 32'(0));
        chk("rst_abs", {20'h0, A, B, Select, Carry, 1'b0}, 32'(0));

        // Add: 7+9 -> 0x10 carry 1, two cycles after accept
        run_op(4'd7, 4'd9, 2'b00, 8'h10, 1'b1, 1'b0, 2, 0, "add_valid");

        // Multiply 13*11 with Done 8 cycles after Init
        drop_k = 0; rise_k = 8;
        run_op(4'd13, 4'd11, 2'b10, 8'h8F, 1'b0, 1'b0, 10, 1, "mul_valid");

        // Stale Done still high from the previous multiply
        chk("stale_done_present", 32'(Done), 32'(1));
        drop_k = 2; rise_k = 8;
        run_op(4'd3, 4'd5, 2'b10, 8'h0F, 1'b0, 1'b0, 10, 1, "stale_valid");

        // Timeout: Done never comes
        drop_k = 0; rise_k = 1000;
        run_op(4'd2, 4'd2, 2'b10, 8'h00, 1'b0, 1'b1, 34, 1, "timeout_valid");
        run_op(4'hC, 4'hA, 2'b11, 8'h08, 1'b0, 1'b0, 2, 0, "and_valid");

        // Handshake: Start during LOAD and HOLD ignored, Start+Ack not queued
        push(4'd1, 4'd2, 2'b00, 8'h03, 1'b0, 1'b0, 2, 0);
        @(negedge Clk);
        OpA = 4'd1; OpB = 4'd2; OpSel = 2'b00; Start = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        wait_valid("hs_valid");
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("hs_valid_holds", 32'(Valid), 32'(1));
        chk("hs_busy_holds", 32'(Busy), 32'(1));
        Start = 1'b1; Ack = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Ack = 1'b0;
        chk("hs_busy_after_ack", 32'(Busy), 32'(0));
        repeat (3) @(negedge Clk);
        chk("hs_no_queued_start", 32'(Busy), 32'(0));
        run_op(4'd5, 4'd7, 2'b01, 8'h0E, 1'b1, 1'b0, 2, 0, "sub_borrow_valid");

        // Reset in the middle of the Init pulse
        drop_k = 0; rise_k = 8;
        push(4'd4, 4'd4, 2'b10, 8'h10, 1'b0, 1'b0, 10, 1);
        start_op(4'd4, 4'd4, 2'b10);
        @(negedge Clk);
        chk("init_in_pulse", 32'(Init), 32'(1));
        #2 Rst = 1'b0;
        #1;
        chk("rst_mid_init", 32'(Init), 32'(0));
        chk("rst_mid_busy", 32'(Busy), 32'(0));
        chk("rst_mid_valid", 32'(Valid), 32'(0));
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        chk("rst_mid_select", 32'(Select), 32'(0));
        run_op(4'd9, 4'd3, 2'b01, 8'h06, 1'b0, 1'b0, 2, 0, "sub_after_rst_valid");

        repeat (3) @(negedge Clk);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
